// File: rtl/cordic_sweep_pkg.sv
// rtl/cordic_sweep_pkg.sv - shared widths, state encoding and helpers for the cordic sweep controller
package cordic_sweep_pkg;

    localparam int PHASE_W  = 32;
    localparam int DATA_W   = 20;
    localparam int DWELL_W  = 16;
    localparam int POINTS_W = 12;
    // Wide enough for DATA_W-bit samples summed over the largest dwell.
    localparam int ACC_W    = DATA_W + DWELL_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACCUM,
        ST_OUTPUT,
        ST_DONE
    } state_t;

    // A dwell of zero would never produce a sample; treat it as one.
    function automatic logic [DWELL_W-1:0] eff_dwell(input logic [DWELL_W-1:0] d);
        return (d == '0) ? DWELL_W'(1) : d;
    endfunction

endpackage

// File: rtl/cordic_sweep_ctrl_if.sv
// rtl/cordic_sweep_ctrl_if.sv - per-point result valid/ready interface
// master: res_valid, res_index, res_re, res_im out; res_ready in.
// slave : the mirror image (host / FIFO side).
interface cordic_sweep_ctrl_if;
    import cordic_sweep_pkg::*;

    logic                       res_valid;
    logic                       res_ready;
    logic [POINTS_W-1:0]        res_index;
    logic signed [ACC_W-1:0]    res_re;
    logic signed [ACC_W-1:0]    res_im;

    modport master (
        output res_valid, res_index, res_re, res_im,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_index, res_re, res_im,
        output res_ready
    );
endinterface

// File: rtl/sweep_accum.sv
// rtl/sweep_accum.sv - dual-channel signed accumulator with clear and enable
// Ports: clock, reset (sync, active-high), clr (zero both sums), en (add inputs),
//        in_re/in_im (signed IN_W samples), acc_re/acc_im (signed OUT_W sums).
module sweep_accum #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 36
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [IN_W-1:0]  in_re,
    input  logic signed [IN_W-1:0]  in_im,
    output logic signed [OUT_W-1:0] acc_re,
    output logic signed [OUT_W-1:0] acc_im
);

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if (en) begin
            // Size cast of a signed operand sign-extends.
            acc_re <= acc_re + OUT_W'(in_re);
            acc_im <= acc_im + OUT_W'(in_im);
        end
    end

endmodule

// File: rtl/cordic_sweep_ctrl.sv
// rtl/cordic_sweep_ctrl.sv - steps the cordic NCO through a frequency sweep and integrates each point
// Ports: clock, reset (sync, active-high); start/abort control; cfg_* sweep setup
//        latched on start; phase_inc tuning word to the cordic; cordic_re/im samples
//        back from it; res (master) one accumulated result per point; busy, done status.
module cordic_sweep_ctrl
    import cordic_sweep_pkg::*;
#(
    parameter int SETTLE = 24
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [PHASE_W-1:0]       cfg_start_inc,
    input  logic [PHASE_W-1:0]       cfg_step_inc,
    input  logic [POINTS_W-1:0]      cfg_points,
    input  logic [DWELL_W-1:0]       cfg_dwell,
    output logic [PHASE_W-1:0]       phase_inc,
    input  logic signed [DATA_W-1:0] cordic_re,
    input  logic signed [DATA_W-1:0] cordic_im,
    cordic_sweep_ctrl_if.master      res,
    output logic                     busy,
    output logic                     done
);

    state_t                 state_q, state_d;
    logic [PHASE_W-1:0]     phase_q, phase_d;
    logic [PHASE_W-1:0]     step_q, step_d;
    logic [POINTS_W-1:0]    points_q, points_d;
    logic [DWELL_W-1:0]     dwell_q, dwell_d;
    logic [POINTS_W-1:0]    idx_q, idx_d;
    // Shared by the settle and dwell phases; SETTLE <= 255 always fits.
    logic [DWELL_W-1:0]     cnt_q, cnt_d;
    logic                   acc_clr;
    logic                   acc_en;
    logic signed [ACC_W-1:0] acc_re;
    logic signed [ACC_W-1:0] acc_im;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            step_q   <= '0;
            points_q <= '0;
            dwell_q  <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            step_q   <= step_d;
            points_q <= points_d;
            dwell_q  <= dwell_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        step_d   = step_q;
        points_d = points_q;
        dwell_d  = dwell_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    step_d   = cfg_step_inc;
                    points_d = cfg_points;
                    dwell_d  = eff_dwell(cfg_dwell);
                    idx_d    = '0;
                    cnt_d    = '0;
                    if (cfg_points == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        phase_d = cfg_start_inc;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == DWELL_W'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    acc_clr = 1'b1;
                    state_d = ST_ACCUM;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            ST_ACCUM: begin
                acc_en = 1'b1;
                if (cnt_q == dwell_q - DWELL_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_OUTPUT;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            ST_OUTPUT: begin
                if (res.res_ready) begin
                    if ((idx_q + POINTS_W'(1)) < points_q) begin
                        idx_d   = idx_q + POINTS_W'(1);
                        phase_d = phase_q + step_q;
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort beats everything, including a final handshake; tuning word holds.
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            phase_d = phase_q;
            idx_d   = idx_q;
            cnt_d   = '0;
            acc_clr = 1'b0;
            acc_en  = 1'b0;
        end
    end

    sweep_accum #(
        .IN_W  (DATA_W),
        .OUT_W (ACC_W)
    ) u_accum (
        .clock  (clock),
        .reset  (reset),
        .clr    (acc_clr),
        .en     (acc_en),
        .in_re  (cordic_re),
        .in_im  (cordic_im),
        .acc_re (acc_re),
        .acc_im (acc_im)
    );

    // Accumulators are idle outside ACCUM, so the result stays stable while presented.
    assign res.res_valid = (state_q == ST_OUTPUT);
    assign res.res_index = idx_q;
    assign res.res_re    = acc_re;
    assign res.res_im    = acc_im;
    assign phase_inc     = phase_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);

endmodule
